// File: rtl/sargantana_sim_pkg.sv
// Shared definitions for the simulation-top refill router: FSM states,
// default bootrom window and line-offset helpers.
package sargantana_sim_pkg;

    localparam int unsigned PADDR_W_DEF        = 40;
    localparam int unsigned LINE_W_DEF         = 128;
    localparam logic [63:0] BROM_BASE_DEF      = 64'h0;
    localparam logic [63:0] BROM_SIZE_DEF      = 64'h1_0000;
    localparam int unsigned BROM_ADDR_W_DEF    = 24;
    localparam int unsigned TIMEOUT_CYCLES_DEF = 1024;

    // Number of byte-offset bits inside one refill line.
    function automatic int unsigned line_off_w(input int unsigned line_w);
        return $clog2(line_w / 8);
    endfunction

    localparam int unsigned LINE_OFF_W = line_off_w(LINE_W_DEF);

    typedef enum logic [2:0] {
        IDLE,
        BROM_REQ,
        BROM_WAIT,
        L2_WAIT,
        DRAIN
    } refill_state_t;

endpackage

// File: rtl/icache_refill_router.sv
// Routes single outstanding icache line refills to the bootrom or the L2 model,
// with kill draining and a busy-cycle watchdog.
module icache_refill_router
    import sargantana_sim_pkg::*;
#(
    parameter int unsigned        PADDR_W        = PADDR_W_DEF,
    parameter int unsigned        LINE_W         = LINE_W_DEF,
    parameter logic [PADDR_W-1:0] BROM_BASE      = PADDR_W'(BROM_BASE_DEF),
    parameter logic [PADDR_W-1:0] BROM_SIZE      = PADDR_W'(BROM_SIZE_DEF),
    parameter int unsigned        BROM_ADDR_W    = BROM_ADDR_W_DEF,
    parameter int unsigned        TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic                   clk_i,
    input  logic                   rstn_i,
    input  logic                   ic_req_valid_i,
    input  logic [PADDR_W-1:0]     ic_req_paddr_i,
    output logic                   ic_req_ready_o,
    input  logic                   ic_kill_i,
    output logic                   ic_resp_valid_o,
    output logic [LINE_W-1:0]      ic_resp_data_o,
    output logic                   ic_resp_err_o,
    output logic                   brom_req_valid_o,
    output logic [BROM_ADDR_W-1:0] brom_req_address_o,
    input  logic                   brom_ready_i,
    input  logic                   brom_resp_valid_i,
    input  logic [LINE_W-1:0]      brom_resp_data_i,
    output logic                   l2_req_valid_o,
    output logic [PADDR_W-1:0]     l2_req_paddr_o,
    input  logic                   l2_resp_valid_i,
    input  logic [LINE_W-1:0]      l2_resp_data_i
);

    localparam int unsigned OFF_W   = line_off_w(LINE_W);
    localparam int unsigned TIMER_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TIMER_W-1:0]     TIMER_MAX   = '1;
    localparam logic [TIMER_W-1:0]     TIMEOUT_VAL = TIMER_W'(TIMEOUT_CYCLES);
    localparam bit                     WDOG_EN     = (TIMEOUT_CYCLES != 0);
    localparam logic [BROM_ADDR_W-1:0] ALIGN_MASK  = ~BROM_ADDR_W'((64'd1 << OFF_W) - 64'd1);

    refill_state_t          state_q, state_d;
    logic [TIMER_W-1:0]     timer_q, timer_d, timer_inc;
    logic [PADDR_W:0]       req_diff;
    logic                   req_hit;
    logic [BROM_ADDR_W-1:0] req_brom_addr;
    logic                   accept, data_fire, tmo_fire, timeout;
    logic                   target_resp;
    logic [LINE_W-1:0]      target_data;

    logic                   sel_brom_q;
    logic [PADDR_W-1:0]     paddr_q;
    logic [BROM_ADDR_W-1:0] brom_addr_q;
    logic                   ready_q, brom_vld_q, l2_vld_q, resp_vld_q, resp_err_q;
    logic [LINE_W-1:0]      resp_data_q;

    // Window decode: the extra borrow bit rejects addresses below the base.
    assign req_diff      = {1'b0, ic_req_paddr_i} - {1'b0, BROM_BASE};
    assign req_hit       = !req_diff[PADDR_W] && (req_diff[PADDR_W-1:0] < BROM_SIZE);
    assign req_brom_addr = BROM_ADDR_W'(req_diff[PADDR_W-1:0]) & ALIGN_MASK;

    assign target_resp = sel_brom_q ? brom_resp_valid_i : l2_resp_valid_i;
    assign target_data = sel_brom_q ? brom_resp_data_i : l2_resp_data_i;

    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        data_fire = 1'b0;
        tmo_fire  = 1'b0;
        timer_inc = (timer_q == TIMER_MAX) ? timer_q : timer_q + TIMER_W'(1);
        timeout   = WDOG_EN && (timer_inc == TIMEOUT_VAL);

        unique case (state_q)
            IDLE: begin
                if (ic_req_valid_i && !ic_kill_i) begin
                    accept  = 1'b1;
                    state_d = req_hit ? BROM_REQ : L2_WAIT;
                end
            end
            BROM_REQ: begin
                // A kill racing the handshake still leaves a bootrom response in flight.
                if (ic_kill_i) begin
                    state_d = brom_ready_i ? DRAIN : IDLE;
                end else if (brom_ready_i) begin
                    state_d = BROM_WAIT;
                end else if (timeout) begin
                    tmo_fire = 1'b1;
                    state_d  = IDLE;
                end
            end
            BROM_WAIT, L2_WAIT: begin
                if (target_resp) begin
                    data_fire = !ic_kill_i;
                    state_d   = IDLE;
                end else if (ic_kill_i) begin
                    state_d = DRAIN;
                end else if (timeout) begin
                    tmo_fire = 1'b1;
                    state_d  = IDLE;
                end
            end
            DRAIN: begin
                if (target_resp || timeout) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Watchdog restarts on every busy-state entry and counts busy cycles.
        if (state_d != IDLE && state_d != state_q) begin
            timer_d = '0;
        end else if (state_q != IDLE) begin
            timer_d = timer_inc;
        end else begin
            timer_d = timer_q;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= IDLE;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end

    // Request capture and registered outputs, derived from the next state.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sel_brom_q  <= 1'b0;
            paddr_q     <= '0;
            brom_addr_q <= '0;
            ready_q     <= 1'b1;
            brom_vld_q  <= 1'b0;
            l2_vld_q    <= 1'b0;
            resp_vld_q  <= 1'b0;
            resp_err_q  <= 1'b0;
            resp_data_q <= '0;
        end else begin
            ready_q    <= (state_d == IDLE);
            brom_vld_q <= (state_d == BROM_REQ);
            l2_vld_q   <= (state_d == L2_WAIT);
            resp_vld_q <= data_fire || tmo_fire;
            resp_err_q <= tmo_fire;
            if (accept) begin
                sel_brom_q  <= req_hit;
                paddr_q     <= ic_req_paddr_i;
                brom_addr_q <= req_brom_addr;
            end
            if (data_fire) begin
                resp_data_q <= target_data;
            end else if (tmo_fire) begin
                resp_data_q <= '0;
            end
        end
    end

    assign ic_req_ready_o     = ready_q;
    assign ic_resp_valid_o    = resp_vld_q;
    assign ic_resp_data_o     = resp_data_q;
    assign ic_resp_err_o      = resp_err_q;
    assign brom_req_valid_o   = brom_vld_q;
    assign brom_req_address_o = brom_addr_q;
    assign l2_req_valid_o     = l2_vld_q;
    assign l2_req_paddr_o     = paddr_q;

endmodule

// File: tb/tb_icache_refill_router.sv
// Scoreboard bench for icache_refill_router: refills queue their expected
// response, a negedge monitor pops and compares every response pulse.
module tb_icache_refill_router;

    localparam int unsigned PADDR_W     = 40;
    localparam int unsigned LINE_W      = 128;
    localparam int unsigned BROM_ADDR_W = 24;
    localparam int unsigned TMO         = 16;

    logic                   tb_clk = 1'b0;
    logic                   tb_rstn;
    logic                   ic_req_valid_i;
    logic [PADDR_W-1:0]     ic_req_paddr_i;
    logic                   ic_req_ready_o;
    logic                   ic_kill_i;
    logic                   ic_resp_valid_o;
    logic [LINE_W-1:0]      ic_resp_data_o;
    logic                   ic_resp_err_o;
    logic                   brom_req_valid_o;
    logic [BROM_ADDR_W-1:0] brom_req_address_o;
    logic                   brom_ready_i;
    logic                   brom_resp_valid_i;
    logic [LINE_W-1:0]      brom_resp_data_i;
    logic                   l2_req_valid_o;
    logic [PADDR_W-1:0]     l2_req_paddr_o;
    logic                   l2_resp_valid_i;
    logic [LINE_W-1:0]      l2_resp_data_i;

    typedef struct packed {
        logic [LINE_W-1:0] data;
        logic              err;
    } resp_t;

    resp_t exp_q[$];
    resp_t mon_exp;
    int    total = 0;
    int    bad   = 0;

    icache_refill_router #(
        .PADDR_W       (PADDR_W),
        .LINE_W        (LINE_W),
        .BROM_ADDR_W   (BROM_ADDR_W),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk_i             (tb_clk),
        .rstn_i            (tb_rstn),
        .ic_req_valid_i    (ic_req_valid_i),
        .ic_req_paddr_i    (ic_req_paddr_i),
        .ic_req_ready_o    (ic_req_ready_o),
        .ic_kill_i         (ic_kill_i),
        .ic_resp_valid_o   (ic_resp_valid_o),
        .ic_resp_data_o    (ic_resp_data_o),
        .ic_resp_err_o     (ic_resp_err_o),
        .brom_req_valid_o  (brom_req_valid_o),
        .brom_req_address_o(brom_req_address_o),
        .brom_ready_i      (brom_ready_i),
        .brom_resp_valid_i (brom_resp_valid_i),
        .brom_resp_data_i  (brom_resp_data_i),
        .l2_req_valid_o    (l2_req_valid_o),
        .l2_req_paddr_o    (l2_req_paddr_o),
        .l2_resp_valid_i   (l2_resp_valid_i),
        .l2_resp_data_i    (l2_resp_data_i)
    );

    always #5 tb_clk = ~tb_clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running at %0t, required finish", $time);
        $fatal(1);
    end

    // Every response pulse must match the head of the scoreboard; err only with valid.
    always @(negedge tb_clk) begin
        if (ic_resp_valid_o === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_resp: got data=%h err=%b, required no pulse",
                         ic_resp_data_o, ic_resp_err_o);
            end else begin
                mon_exp = exp_q.pop_front();
                if (ic_resp_data_o !== mon_exp.data || ic_resp_err_o !== mon_exp.err) begin
                    bad++;
                    $display("FAIL resp_payload: got data=%h err=%b, required data=%h err=%b",
                             ic_resp_data_o, ic_resp_err_o, mon_exp.data, mon_exp.err);
                end
            end
        end else if (tb_rstn === 1'b1) begin
            total++;
            if (ic_resp_err_o !== 1'b0) begin
                bad++;
                $display("FAIL err_without_valid: got err=%b, required 0", ic_resp_err_o);
            end
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) @(posedge tb_clk);
        #1;
    endtask

    task automatic test_reset();
        tb_rstn           = 1'b0;
        ic_req_valid_i    = 1'b0;
        ic_req_paddr_i    = '0;
        ic_kill_i         = 1'b0;
        brom_ready_i      = 1'b1;
        brom_resp_valid_i = 1'b0;
        brom_resp_data_i  = '0;
        l2_resp_valid_i   = 1'b0;
        l2_resp_data_i    = '0;
        #1;
        cyc(2);
        tb_rstn = 1'b1;
        cyc();
        total++;
        if (ic_req_ready_o !== 1'b1 ||
            {brom_req_valid_o, brom_req_address_o, l2_req_valid_o, l2_req_paddr_o,
             ic_resp_valid_o, ic_resp_err_o, ic_resp_data_o} !== '0) begin
            bad++;
            $display("FAIL reset_state: got ready=%b brom_v=%b brom_a=%h l2_v=%b l2_a=%h rv=%b err=%b, required ready=1 rest 0",
                     ic_req_ready_o, brom_req_valid_o, brom_req_address_o, l2_req_valid_o,
                     l2_req_paddr_o, ic_resp_valid_o, ic_resp_err_o);
        end
    endtask

    task automatic test_brom_hit();
        logic [LINE_W-1:0] d = {4{32'hB007_0001}};
        ic_req_valid_i = 1'b1;
        ic_req_paddr_i = 40'h100;
        brom_ready_i   = 1'b1;
        cyc();
        ic_req_valid_i = 1'b0;
        total++;
        if (brom_req_valid_o !== 1'b1 || brom_req_address_o !== 24'h100 || ic_req_ready_o !== 1'b0) begin
            bad++;
            $display("FAIL brom_hit_req: got v=%b addr=%h ready=%b, required v=1 addr=000100 ready=0",
                     brom_req_valid_o, brom_req_address_o, ic_req_ready_o);
        end
        cyc();
        total++;
        if (brom_req_valid_o !== 1'b0 || l2_req_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL brom_hit_wait: got brom_v=%b l2_v=%b, required 0 0", brom_req_valid_o, l2_req_valid_o);
        end
        cyc(2);
        brom_resp_valid_i = 1'b1;
        brom_resp_data_i  = d;
        exp_q.push_back({d, 1'b0});
        cyc();
        brom_resp_valid_i = 1'b0;
        brom_resp_data_i  = '0;
        total++;
        if (ic_resp_valid_o !== 1'b1 || ic_req_ready_o !== 1'b1) begin
            bad++;
            $display("FAIL brom_hit_pulse: got rv=%b ready=%b, required 1 1", ic_resp_valid_o, ic_req_ready_o);
        end
        cyc();
        total++;
        if (ic_resp_valid_o !== 1'b0 || ic_resp_data_o !== d) begin
            bad++;
            $display("FAIL brom_hit_hold: got rv=%b data=%h, required rv=0 data=%h", ic_resp_valid_o, ic_resp_data_o, d);
        end
    endtask

    task automatic test_l2_path();
        logic [LINE_W-1:0] d = {32'h1234_5678, 32'h9ABC_DEF0, 32'h0F1E_2D3C, 32'h4B5A_6978};
        int hi = 0;
        bit brom_seen = 1'b0;
        ic_req_valid_i = 1'b1;
        ic_req_paddr_i = 40'h80_0000_40;
        ic_req_paddr_i = 40'h00_8000_0040;
        cyc();
        ic_req_valid_i = 1'b0;
        total++;
        if (l2_req_paddr_o !== 40'h00_8000_0040) begin
            bad++;
            $display("FAIL l2_paddr: got %h, required 0080000040", l2_req_paddr_o);
        end
        for (int i = 0; i < 10; i++) begin
            if (l2_req_valid_o === 1'b1) hi++;
            if (brom_req_valid_o !== 1'b0) brom_seen = 1'b1;
            cyc();
        end
        l2_resp_valid_i = 1'b1;
        l2_resp_data_i  = d;
        exp_q.push_back({d, 1'b0});
        if (l2_req_valid_o === 1'b1) hi++;
        cyc();
        l2_resp_valid_i = 1'b0;
        l2_resp_data_i  = '0;
        total++;
        if (hi != 11 || l2_req_valid_o !== 1'b0 || brom_seen) begin
            bad++;
            $display("FAIL l2_req_level: got high_cycles=%0d after=%b brom_seen=%b, required 11 0 0",
                     hi, l2_req_valid_o, brom_seen);
        end
        total++;
        if (ic_resp_valid_o !== 1'b1) begin
            bad++;
            $display("FAIL l2_pulse: got rv=%b, required 1", ic_resp_valid_o);
        end
        cyc();
    endtask

    task automatic test_brom_backpressure();
        logic [LINE_W-1:0] d = {4{32'h5EED_CAFE}};
        int hi = 0;
        bit bad_side = 1'b0;
        brom_ready_i   = 1'b0;
        ic_req_valid_i = 1'b1;
        ic_req_paddr_i = 40'h2347;
        cyc();
        ic_req_valid_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (brom_req_valid_o === 1'b1) hi++;
            if (l2_req_valid_o !== 1'b0 || ic_req_ready_o !== 1'b0) bad_side = 1'b1;
            cyc();
        end
        brom_ready_i = 1'b1;
        if (brom_req_valid_o === 1'b1) hi++;
        if (brom_req_address_o !== 24'h2340) bad_side = 1'b1;
        cyc();
        total++;
        if (hi != 6 || brom_req_valid_o !== 1'b0 || ic_req_ready_o !== 1'b0 || bad_side) begin
            bad++;
            $display("FAIL brom_backpressure: got high_cycles=%0d after=%b ready=%b side=%b addr=%h, required 6 0 0 0 002340",
                     hi, brom_req_valid_o, ic_req_ready_o, bad_side, brom_req_address_o);
        end
        brom_resp_valid_i = 1'b1;
        brom_resp_data_i  = d;
        exp_q.push_back({d, 1'b0});
        cyc();
        brom_resp_valid_i = 1'b0;
        total++;
        if (ic_resp_valid_o !== 1'b1) begin
            bad++;
            $display("FAIL brom_bp_pulse: got rv=%b, required 1", ic_resp_valid_o);
        end
        cyc();
    endtask

    task automatic test_decode_boundary();
        logic [LINE_W-1:0] d0 = {4{32'h0001_0000}};
        logic [LINE_W-1:0] d1 = {4{32'h0000_FFF0}};
        ic_req_valid_i = 1'b1;
        ic_req_paddr_i = 40'h1_0000;
        cyc();
        ic_req_valid_i = 1'b0;
        total++;
        if (l2_req_valid_o !== 1'b1 || brom_req_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL window_end_l2: got l2_v=%b brom_v=%b, required 1 0", l2_req_valid_o, brom_req_valid_o);
        end
        l2_resp_valid_i = 1'b1;
        l2_resp_data_i  = d0;
        exp_q.push_back({d0, 1'b0});
        cyc();
        l2_resp_valid_i = 1'b0;
        cyc();
        ic_req_valid_i = 1'b1;
        ic_req_paddr_i = 40'hFFF0;
        cyc();
        ic_req_valid_i = 1'b0;
        total++;
        if (brom_req_valid_o !== 1'b1 || brom_req_address_o !== 24'hFFF0 || l2_req_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL window_last_brom: got brom_v=%b addr=%h l2_v=%b, required 1 00fff0 0",
                     brom_req_valid_o, brom_req_address_o, l2_req_valid_o);
        end
        cyc();
        brom_resp_valid_i = 1'b1;
        brom_resp_data_i  = d1;
        exp_q.push_back({d1, 1'b0});
        cyc();
        brom_resp_valid_i = 1'b0;
        cyc();
    endtask

    task automatic test_kill_l2_drain();
        ic_req_valid_i = 1'b1;
        ic_req_paddr_i = 40'h00_8000_1000;
        cyc();
        ic_req_valid_i = 1'b0;
        cyc(2);
        ic_kill_i = 1'b1;
        cyc();
        ic_kill_i = 1'b0;
        total++;
        if (l2_req_valid_o !== 1'b0 || ic_req_ready_o !== 1'b0) begin
            bad++;
            $display("FAIL kill_drain_enter: got l2_v=%b ready=%b, required 0 0", l2_req_valid_o, ic_req_ready_o);
        end
        brom_resp_valid_i = 1'b1;
        cyc();
        brom_resp_valid_i = 1'b0;
        cyc(2);
        total++;
        if (ic_req_ready_o !== 1'b0) begin
            bad++;
            $display("FAIL drain_ignores_brom: got ready=%b, required 0", ic_req_ready_o);
        end
        l2_resp_valid_i = 1'b1;
        l2_resp_data_i  = {4{32'hDEAD_BEEF}};
        cyc();
        l2_resp_valid_i = 1'b0;
        total++;
        if (ic_req_ready_o !== 1'b1 || ic_resp_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL drain_exit: got ready=%b rv=%b, required 1 0", ic_req_ready_o, ic_resp_valid_o);
        end
        cyc();
    endtask

    task automatic test_kill_corners();
        brom_ready_i   = 1'b0;
        ic_req_valid_i = 1'b1;
        ic_req_paddr_i = 40'h300;
        cyc();
        ic_req_valid_i = 1'b0;
        ic_kill_i      = 1'b1;
        cyc();
        ic_kill_i    = 1'b0;
        brom_ready_i = 1'b1;
        total++;
        if (brom_req_valid_o !== 1'b0 || ic_req_ready_o !== 1'b1) begin
            bad++;
            $display("FAIL kill_brom_req: got brom_v=%b ready=%b, required 0 1", brom_req_valid_o, ic_req_ready_o);
        end
        ic_req_valid_i = 1'b1;
        ic_req_paddr_i = 40'h00_8000_3000;
        cyc();
        ic_req_valid_i  = 1'b0;
        ic_kill_i       = 1'b1;
        l2_resp_valid_i = 1'b1;
        cyc();
        ic_kill_i       = 1'b0;
        l2_resp_valid_i = 1'b0;
        total++;
        if (ic_req_ready_o !== 1'b1 || ic_resp_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL kill_with_resp: got ready=%b rv=%b, required 1 0", ic_req_ready_o, ic_resp_valid_o);
        end
        ic_req_valid_i = 1'b1;
        ic_kill_i      = 1'b1;
        cyc();
        ic_req_valid_i = 1'b0;
        ic_kill_i      = 1'b0;
        total++;
        if (ic_req_ready_o !== 1'b1 || l2_req_valid_o !== 1'b0 || brom_req_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL kill_blocks_accept: got ready=%b l2_v=%b brom_v=%b, required 1 0 0",
                     ic_req_ready_o, l2_req_valid_o, brom_req_valid_o);
        end
    endtask

    task automatic test_timeout();
        int hi = 0;
        bit seen = 1'b0;
        ic_req_valid_i = 1'b1;
        ic_req_paddr_i = 40'h00_8000_2000;
        exp_q.push_back({{LINE_W{1'b0}}, 1'b1});
        cyc();
        ic_req_valid_i = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (ic_resp_valid_o === 1'b1) begin
                seen = 1'b1;
            end else begin
                if (l2_req_valid_o === 1'b1) hi++;
                cyc();
            end
        end
        total++;
        if (!seen || hi != int'(TMO) || ic_resp_err_o !== 1'b1 || ic_resp_data_o !== '0) begin
            bad++;
            $display("FAIL timeout_pulse: got seen=%b busy=%0d err=%b data=%h, required seen=1 busy=%0d err=1 data=0",
                     seen, hi, ic_resp_err_o, ic_resp_data_o, TMO);
        end
        cyc();
        l2_resp_valid_i = 1'b1;
        l2_resp_data_i  = {4{32'h5757_5757}};
        cyc();
        l2_resp_valid_i = 1'b0;
        total++;
        if (ic_resp_valid_o !== 1'b0 || ic_req_ready_o !== 1'b1) begin
            bad++;
            $display("FAIL stray_after_timeout: got rv=%b ready=%b, required 0 1", ic_resp_valid_o, ic_req_ready_o);
        end
        cyc();
    endtask

    task automatic test_drain_timeout();
        int busy = 0;
        bit back = 1'b0;
        ic_req_valid_i = 1'b1;
        ic_req_paddr_i = 40'h00_8000_4000;
        cyc();
        ic_req_valid_i = 1'b0;
        ic_kill_i      = 1'b1;
        cyc();
        ic_kill_i = 1'b0;
        for (int i = 0; i < 40 && !back; i++) begin
            if (ic_req_ready_o === 1'b1) begin
                back = 1'b1;
            end else begin
                busy++;
                cyc();
            end
        end
        total++;
        if (!back || busy != int'(TMO) || ic_resp_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL drain_timeout: got back=%b drain_cycles=%0d rv=%b, required 1 %0d 0",
                     back, busy, ic_resp_valid_o, TMO);
        end
        cyc();
    endtask

    task automatic test_reset_mid();
        logic [LINE_W-1:0] d = {4{32'hA11C_E000}};
        ic_req_valid_i = 1'b1;
        ic_req_paddr_i = 40'h200;
        cyc();
        ic_req_valid_i = 1'b0;
        cyc(2);
        tb_rstn = 1'b0;
        #1;
        total++;
        if (ic_req_ready_o !== 1'b1 ||
            {brom_req_valid_o, brom_req_address_o, l2_req_valid_o, l2_req_paddr_o,
             ic_resp_valid_o, ic_resp_err_o, ic_resp_data_o} !== '0) begin
            bad++;
            $display("FAIL reset_mid: got ready=%b brom_v=%b brom_a=%h l2_v=%b l2_a=%h rv=%b data=%h, required ready=1 rest 0",
                     ic_req_ready_o, brom_req_valid_o, brom_req_address_o, l2_req_valid_o,
                     l2_req_paddr_o, ic_resp_valid_o, ic_resp_data_o);
        end
        brom_resp_valid_i = 1'b1;
        cyc();
        brom_resp_valid_i = 1'b0;
        tb_rstn = 1'b1;
        cyc();
        ic_req_valid_i = 1'b1;
        ic_req_paddr_i = 40'h400;
        cyc();
        ic_req_valid_i = 1'b0;
        total++;
        if (brom_req_valid_o !== 1'b1 || brom_req_address_o !== 24'h400) begin
            bad++;
            $display("FAIL post_reset_req: got v=%b addr=%h, required 1 000400", brom_req_valid_o, brom_req_address_o);
        end
        cyc();
        brom_resp_valid_i = 1'b1;
        brom_resp_data_i  = d;
        exp_q.push_back({d, 1'b0});
        cyc();
        brom_resp_valid_i = 1'b0;
        total++;
        if (ic_resp_valid_o !== 1'b1 || ic_resp_data_o !== d) begin
            bad++;
            $display("FAIL post_reset_pulse: got rv=%b data=%h, required 1 %h", ic_resp_valid_o, ic_resp_data_o, d);
        end
        cyc(2);
    endtask

    initial begin
        test_reset();
        test_brom_hit();
        test_l2_path();
        test_brom_backpressure();
        test_decode_boundary();
        test_kill_l2_drain();
        test_kill_corners();
        test_timeout();
        test_drain_timeout();
        test_reset_mid();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_leftover: got %0d pending responses, required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
